// File: rtl/wavelet_scheduler.sv
// wavelet_scheduler: shifts accepted samples into a tap delay line, walks filter_sel over every channel of a shared FIR, emits each sum via valid/ready.
// First result 1+FIR_LATENCY cycles after accept; EMIT holds everything stable under out_ready=0. WAVELET_SCHED_FLUSH_EN adds an IDLE-only flush input.
module wavelet_scheduler #(
   parameter int BITS_PER_ELEM = 8,
   parameter int NUM_ELEM      = 7,
   parameter int NUM_FILTERS   = 4,
   parameter int SUM_WIDTH     = 12,
   parameter int FIR_LATENCY   = 1,
   localparam int SEL_W        = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [BITS_PER_ELEM-1:0]          in_sample,
`ifdef WAVELET_SCHED_FLUSH_EN
   input  logic                              flush,
`endif
   output logic [NUM_ELEM*BITS_PER_ELEM-1:0] taps,
   output logic [SEL_W-1:0]                  filter_sel,
   input  logic [SUM_WIDTH-1:0]              fir_sum,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [SUM_WIDTH-1:0]              out_sum,
   output logic [SEL_W-1:0]                  out_channel,
   output logic                              busy
);

   localparam int CNT_W = (FIR_LATENCY > 1) ? $clog2(FIR_LATENCY) : 1;
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(FIR_LATENCY - 1);
   localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_FILTERS - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

   state_t                   state, state_nxt;
   logic [CNT_W-1:0]         wait_cnt, wait_cnt_nxt;
   logic [SEL_W-1:0]         sel_nxt;
   logic                     shift_en, clear_en, capture_en;
   logic                     flush_req;
   logic [BITS_PER_ELEM-1:0] line [NUM_ELEM];

`ifdef WAVELET_SCHED_FLUSH_EN
   assign flush_req = flush;
`else
   assign flush_req = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      sel_nxt      = filter_sel;
      shift_en     = 1'b0;
      clear_en     = 1'b0;
      capture_en   = 1'b0;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      busy         = 1'b1;
      unique case (state)
         IDLE: begin
            busy     = 1'b0;
            // flush outranks a sample and blocks the handshake for that cycle
            in_ready = !flush_req;
            if (flush_req) begin
               clear_en = 1'b1;
            end else if (in_valid) begin
               shift_en  = 1'b1;
               sel_nxt   = '0;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            wait_cnt_nxt = WAIT_LOAD;
            state_nxt    = WAIT;
         end
         WAIT: begin
            if (wait_cnt == '0) begin
               capture_en = 1'b1;
               state_nxt  = EMIT;
            end else begin
               wait_cnt_nxt = wait_cnt - CNT_W'(1);
            end
         end
         EMIT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (filter_sel == LAST_SEL) begin
                  sel_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  sel_nxt   = filter_sel + SEL_W'(1);
                  state_nxt = ISSUE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt    <= '0;
         filter_sel  <= '0;
         out_sum     <= '0;
         out_channel <= '0;
      end else begin
         wait_cnt   <= wait_cnt_nxt;
         filter_sel <= sel_nxt;
         if (capture_en) begin
            out_sum     <= fir_sum;
            out_channel <= filter_sel;
         end
      end
   end

   // Element 0 is the newest sample; the oldest falls off the far end.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NUM_ELEM; k++) line[k] <= '0;
      end else if (clear_en) begin
         for (int k = 0; k < NUM_ELEM; k++) line[k] <= '0;
      end else if (shift_en) begin
         for (int k = NUM_ELEM-1; k > 0; k--) line[k] <= line[k-1];
         line[0] <= in_sample;
      end
   end

   always_comb begin
      taps = '0;
      for (int k = 0; k < NUM_ELEM; k++)
         taps[k*BITS_PER_ELEM +: BITS_PER_ELEM] = line[k];
   end

endmodule

// File: tb/tb_wavelet_scheduler.sv
// Bench for wavelet_scheduler: table-driven directed sequences plus randomized traffic against a queue-based reference.
`timescale 1ns/1ps
module tb_wavelet_scheduler;
   localparam int BPE = 8, NE = 7, NF = 4, SW = 12, FL = 1, SEL_W = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [BPE-1:0]    in_sample = '0;
   logic              flush = 1'b0;
   logic [NE*BPE-1:0] taps;
   logic [SEL_W-1:0]  filter_sel;
   logic [SW-1:0]     fir_sum = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [SW-1:0]     out_sum;
   logic [SEL_W-1:0]  out_channel;
   logic              busy;

   wavelet_scheduler #(.BITS_PER_ELEM(BPE), .NUM_ELEM(NE), .NUM_FILTERS(NF),
                       .SUM_WIDTH(SW), .FIR_LATENCY(FL)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
`ifdef WAVELET_SCHED_FLUSH_EN
      .flush(flush),
`endif
      .taps(taps), .filter_sel(filter_sel), .fir_sum(fir_sum), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_channel(out_channel), .busy(busy));

   always #5 clk = ~clk;

   int vectors = 0, miscompares = 0, cyc = 0, fir_mode = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [SW-1:0] fir_fn(input logic [NE*BPE-1:0] t, input int sel);
      int acc = 0;
      for (int k = 0; k < NE; k++) acc += int'(t[k*BPE +: BPE]) * (k + 1 + 2*sel);
      return SW'(acc);
   endfunction

   // Environment FIR: registered, one cycle of latency
   always @(posedge clk)
      fir_sum <= (fir_mode == 0) ? SW'(100 + int'(filter_sel)) : fir_fn(taps, int'(filter_sel));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
      tick; tick;
      reset = 1'b0;
      tick;
   endtask

   task automatic send_sample(input logic [BPE-1:0] v, output int acc_cyc);
      int n = 0;
      in_sample = v; in_valid = 1'b1;
      while (!in_ready && n < 200) begin tick; n++; end
      if (n >= 200) timeout("send");
      tick;
      acc_cyc = cyc;
      in_valid = 1'b0;
   endtask

   task automatic expect_out(input int ch, input logic [SW-1:0] sum, output int lat);
      int n = 0;
      while (!out_valid && n < 50) begin tick; n++; end
      lat = n;
      if (n >= 50) timeout("expect_out");
      else begin
         check("out_channel", out_channel, ch);
         check("out_sum", out_sum, sum);
         tick;
      end
   endtask

   typedef struct { logic [BPE-1:0] sample; logic [NE*BPE-1:0] exp_taps; } vec_t;
   typedef struct { int ch; logic [SW-1:0] sum; } exp_t;

   initial begin
      vec_t tbl[3];
      exp_t q[$];
      exp_t e;
      logic [BPE-1:0] m[NE];
      logic [NE*BPE-1:0] mp, held;
      int lat, acc_c, prev_c, n, next, nacc, nout;

      tbl[0] = '{8'd1, 56'h00000000000001};
      tbl[1] = '{8'd2, 56'h00000000000102};
      tbl[2] = '{8'd3, 56'h00000000010203};

      // Reset state
      tick;
      check("rst_taps", taps, 0);
      check("rst_sel", filter_sel, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sum", out_sum, 0);
      check("rst_out_channel", out_channel, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_busy", busy, 0);
      reset = 1'b0;
      tick;

      // Samples 1,2,3 at full speed
      prev_c = 0;
      for (int i = 0; i < 3; i++) begin
         send_sample(tbl[i].sample, acc_c);
         if (i > 0) check("sample_period", acc_c - prev_c, 1 + NF*(2+FL));
         prev_c = acc_c;
         for (int ch = 0; ch < NF; ch++) begin
            expect_out(ch, SW'(100 + ch), lat);
            check("out_latency", lat, FL + 1);
         end
         check("table_taps", taps, tbl[i].exp_taps);
         check("idle_sel", filter_sel, 0);
         check("idle_busy", busy, 0);
      end

      // Backpressure on ch1
      send_sample(8'd4, acc_c);
      expect_out(0, SW'(100), lat);
      out_ready = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin tick; n++; end
      held = taps;
      for (int c = 0; c < 6; c++) begin
         check("bp_valid", out_valid, 1);
         check("bp_sum", out_sum, 101);
         check("bp_channel", out_channel, 1);
         check("bp_sel", filter_sel, 1);
         check("bp_taps", taps, held);
         if (c < 5) tick;
      end
      out_ready = 1'b1;
      tick;
      n = 1;
      while (!out_valid && n < 20) begin tick; n++; end
      check("bp_release_gap", n, 3);
      expect_out(2, SW'(102), lat);
      expect_out(3, SW'(103), lat);

      // in_valid held high: only IDLE handshakes shift
      do_reset;
      next = 1; nacc = 0; nout = 0;
      for (int c = 0; c < 300; c++) begin
         in_valid  = (next <= 8);
         in_sample = in_ready ? BPE'(next) : BPE'($urandom_range(9, 255));
         if (in_valid && in_ready) begin nacc++; next++; end
         if (out_valid && out_ready) nout++;
         tick;
         if (next > 8 && in_ready && nout == 32) break;
      end
      in_valid = 1'b0;
      check("stream_taps", taps, 56'h02030405060708);
      check("stream_accepts", nacc, 8);
      check("stream_outputs", nout, 4*nacc);

      // Reset while waiting on ch2
      send_sample(8'd9, acc_c);
      expect_out(0, SW'(100), lat);
      expect_out(1, SW'(101), lat);
      tick;
      check("pre_abort_busy", busy, 1);
      check("pre_abort_sel", filter_sel, 2);
      reset = 1'b1;
      #1;
      check("abort_valid", out_valid, 0);
      check("abort_taps", taps, 0);
      check("abort_sel", filter_sel, 0);
      tick;
      check("abort_hold_valid", out_valid, 0);
      reset = 1'b0;
      tick;
      check("post_abort_ready", in_ready, 1);
      for (int c = 0; c < 4; c++) begin
         check("post_abort_no_out", out_valid, 0);
         tick;
      end

`ifdef WAVELET_SCHED_FLUSH_EN
      for (int i = 0; i < 3; i++) begin
         send_sample(tbl[i].sample, acc_c);
         for (int ch = 0; ch < NF; ch++) expect_out(ch, SW'(100 + ch), lat);
      end
      check("preflush_taps", taps, 56'h010203);
      flush = 1'b1; in_valid = 1'b1; in_sample = 8'h55;
      #1;
      check("flush_in_ready", in_ready, 0);
      tick;
      flush = 1'b0; in_valid = 1'b0;
      check("flush_taps", taps, 0);
      check("flush_no_accept", busy, 0);
      send_sample(8'd7, acc_c);
      flush = 1'b1;
      tick;
      flush = 1'b0;
      check("busy_flush_taps", taps, 56'h07);
      for (int ch = 0; ch < NF; ch++) expect_out(ch, SW'(100 + ch), lat);
`endif

      // Randomized traffic vs. reference queue
      fir_mode = 1;
      do_reset;
      for (int k = 0; k < NE; k++) m[k] = '0;
      nacc = 0;
      for (int c = 0; c < 2000; c++) begin
         in_valid  = ($urandom_range(0, 2) != 0);
         in_sample = BPE'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         if (in_ready) check("rand_no_overlap", q.size(), 0);
         if (in_valid && in_ready) begin
            for (int k = NE-1; k > 0; k--) m[k] = m[k-1];
            m[0] = in_sample;
            for (int k = 0; k < NE; k++) mp[k*BPE +: BPE] = m[k];
            for (int ch = 0; ch < NF; ch++) q.push_back('{ch, fir_fn(mp, ch)});
            nacc++;
         end
         if (out_valid) begin
            for (int k = 0; k < NE; k++) mp[k*BPE +: BPE] = m[k];
            check("rand_taps", taps, mp);
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) timeout("rand_unexpected_output");
            else begin
               e = q.pop_front();
               check("rand_channel", out_channel, e.ch);
               check("rand_sum", out_sum, e.sum);
            end
         end
         tick;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         if (out_valid) begin
            e = q.pop_front();
            check("drain_channel", out_channel, e.ch);
            check("drain_sum", out_sum, e.sum);
         end
         tick;
         n++;
      end
      check("drain_empty", q.size(), 0);
      check("rand_enough_samples", (nacc > 20) ? 1 : 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/wavelet_scheduler.md
Name: wavelet_scheduler

Overview:
Sequences one shared wavelet FIR across a bank of NUM_FILTERS center frequencies.
- Accepts one input sample per valid/ready handshake and shifts it into a NUM_ELEM-deep tap delay line, which drives the FIR `taps` bus.
- Steps `filter_sel` through every channel and waits for the FIR's registered sum.
- Captures each sum and emits it with its channel index over a valid/ready output handshake.
- Sits between the sample source and the FIR/coefficient-mux, upstream of output serialisation.

Parameters:
- BITS_PER_ELEM, 8, width of one sample / tap element.
- NUM_ELEM, 7, delay-line depth; taps bus is NUM_ELEM*BITS_PER_ELEM wide.
- NUM_FILTERS, 4, number of filter channels; legal range is 1 or more.
- SUM_WIDTH, 12, width of the FIR sum; 12 matches the FIR output for 8-bit elements and 7 taps.
- FIR_LATENCY, 1, cycles from a taps/filter_sel change to a valid fir_sum; legal range is 1 or more.
- Derived: SEL_W = max(1, $clog2(NUM_FILTERS)).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  sample available.
- in_ready  output  1  scheduler can accept a sample.
- in_sample  input  BITS_PER_ELEM  new sample.
- taps  output  NUM_ELEM*BITS_PER_ELEM  delay line to the FIR; element 0 (LSBs) is the newest sample.
- filter_sel  output  SEL_W  channel currently driven to the FIR coefficient mux.
- fir_sum  input  SUM_WIDTH  registered FIR result.
- out_valid  output  1  out_sum/out_channel valid.
- out_ready  input  1  downstream accepts the output.
- out_sum  output  SUM_WIDTH  captured FIR result.
- out_channel  output  SEL_W  channel of out_sum.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values (asynchronous, while reset is high):
  - state=IDLE, taps=0, filter_sel=0, out_sum=0, out_channel=0, out_valid=0, busy=0.
  - in_ready=1, decoded from IDLE.
  - Wait counter = 0.
- State machine (registered): IDLE -> ISSUE -> WAIT -> EMIT -> (ISSUE | IDLE).
  - in_ready = (state==IDLE); busy = !in_ready; out_valid = (state==EMIT).
- IDLE, on in_valid && in_ready at edge N:
  - Delay line shifts: element k <= element k-1, element 0 <= in_sample; oldest element dropped.
  - filter_sel <= 0; state -> ISSUE.
- ISSUE: lasts exactly 1 cycle; loads wait counter with FIR_LATENCY-1; state -> WAIT.
- WAIT: counts down.
  - On the edge where counter==0: out_sum <= fir_sum, out_channel <= filter_sel, state -> EMIT.
  - Net effect: out_valid is high from edge N+1+FIR_LATENCY (N+2 at default).
- EMIT: out_valid=1; out_sum, out_channel, filter_sel and taps are held stable while out_ready=0.
  - On out_valid && out_ready with filter_sel < NUM_FILTERS-1: filter_sel <= filter_sel+1, state -> ISSUE.
  - On out_valid && out_ready with filter_sel == NUM_FILTERS-1: filter_sel <= 0, state -> IDLE.
- taps changes only on an accepted input. filter_sel changes only on the edge entering ISSUE or IDLE. Both are constant from ISSUE through EMIT.
- in_valid while busy: ignored, no shift. in_sample is not sampled outside an IDLE handshake.
- NUM_FILTERS=1: one EMIT per sample, then return to IDLE.
- No overlap between samples:
  - IDLE lasts at least 1 cycle between samples.
  - Minimum period per sample = 1 + NUM_FILTERS*(2+FIR_LATENCY) cycles (13 at default with out_ready tied high).
- Widths:
  - fir_sum is captured verbatim, with no extension or truncation.
  - filter_sel and out_channel are zero-based and never exceed NUM_FILTERS-1.
- Reset asserted mid-operation (any state):
  - Immediate abort; the pending output is lost; delay line cleared.
  - After deassertion the block is in IDLE with in_ready=1.

Optional Feature:
- Macro: WAVELET_SCHED_FLUSH_EN.
- Defined: adds input `flush` (1 bit).
  - flush is honoured only in IDLE and has priority over in_valid.
  - At that edge all taps elements <= 0, no sample is accepted, and in_ready=0 during that cycle.
  - flush outside IDLE is ignored.
- Undefined: no `flush` port; the delay line is cleared only by reset.

Test Plan:
- Reset -> taps=0, filter_sel=0, out_valid=0, out_sum=0, out_channel=0, in_ready=1, busy=0.
- Setup for the next three rows: FIR model with latency 1 returns fir_sum = 100+filter_sel; out_ready=1.
  - Send samples 1,2,3 -> taps[7:0]=3, taps[15:8]=2, taps[23:16]=1, upper elements 0.
  - Each sample gives outputs (ch0,100), (ch1,101), (ch2,102), (ch3,103).
  - First out_valid is seen at edge N+2; the sample period is 13 cycles.
- Backpressure: hold out_ready=0 for 5 cycles while (ch1,101) is valid -> out_sum=101, out_channel=1, filter_sel=1 and taps stay stable throughout.
  - ch2 follows 3 cycles after release.
- Hold in_valid=1 with incrementing data 1..8 continuously -> only IDLE handshakes shift.
  - Final taps elements 0..6 = 8,7,6,5,4,3,2; sample 1 is dropped.
  - Exactly 4 outputs per accepted sample.
- Assert reset during WAIT of ch2 -> out_valid stays 0, taps=0, filter_sel=0; in_ready=1 the cycle after deassertion.
- WAVELET_SCHED_FLUSH_EN defined: with taps holding 3,2,1, pulse flush in IDLE together with in_valid -> taps all 0, no sample accepted.
  - flush pulsed while busy leaves taps unchanged.
